// File: rtl/pmp_cfg_pkg.sv
// Shared definitions for the PMP configuration register file: CSR address
// map, pmpcfg byte layout, address-matching mode encoding and the CSR
// handshake state encoding.
package pmp_cfg_pkg;

    // CSR address map
    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;   // pmpcfg0..3  : 0x3A0..0x3A3
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;   // pmpaddr0..15: 0x3B0..0x3BF

    // Architectural maximum number of PMP entries
    localparam int MAX_PMP_ENTRIES = 16;

    // Bits 6:5 of a cfg byte are reserved and always read as zero
    localparam logic [7:0] PMPCFG_WARL_MASK = 8'h9F;

    // Address-matching mode (A field, bits 4:3)
    typedef enum logic [1:0] {
        PMP_A_OFF   = 2'b00,
        PMP_A_TOR   = 2'b01,
        PMP_A_NA4   = 2'b10,
        PMP_A_NAPOT = 2'b11
    } pmp_a_mode_e;

    // One pmpcfg byte
    typedef struct packed {
        logic        locked;    // L, bit 7
        logic [1:0]  reserved;  // bits 6:5
        pmp_a_mode_e mode;      // A, bits 4:3
        logic        x;
        logic        w;
        logic        r;
    } pmpcfg_t;

    // CSR request/response handshake states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } csr_state_e;

    // True when the entry's lock bit is set
    function automatic logic cfg_is_locked(pmpcfg_t cfg);
        return cfg.locked;
    endfunction

    // True when a locked TOR entry also protects the address of the entry below it
    function automatic logic cfg_is_tor_locked(pmpcfg_t cfg);
        return cfg.locked && (cfg.mode == PMP_A_TOR);
    endfunction

endpackage

// File: rtl/pmp_entry_wr.sv
// Per-entry write qualification for one PMP entry: decides whether a cfg
// byte or pmpaddr write may land, and legalises the cfg byte (WARL).
// All decisions use the state stored before the write.
module pmp_entry_wr
    import pmp_cfg_pkg::*;
#(
    parameter int PLEN        = 34,
    parameter bit READ_ONLY   = 1'b0,
    parameter bit IMPLEMENTED = 1'b1
) (
    input  logic            cfg_sel,          // cfg word write covering this entry's byte
    input  logic            addr_sel,         // pmpaddr write targeting this entry
    input  logic [7:0]      cfg_wdata,        // this entry's byte of the write data
    input  logic [PLEN-3:0] addr_wdata,
    input  logic [7:0]      cfg_cur,          // currently stored cfg byte
    input  logic            next_tor_locked,  // entry above is locked in TOR mode
    output logic            cfg_we,
    output logic [7:0]      cfg_new,
    output logic            addr_we,
    output logic [PLEN-3:0] addr_new
);

    pmpcfg_t wr_cfg;
    pmpcfg_t legal_cfg;
    logic    entry_locked;
    logic    warl_reject;

    // Lock/read-only gating and WARL legalisation of the incoming cfg byte
    always_comb begin
        wr_cfg             = pmpcfg_t'(cfg_wdata);
        legal_cfg          = wr_cfg;
        legal_cfg.reserved = 2'b00;
        entry_locked       = cfg_is_locked(pmpcfg_t'(cfg_cur)) || READ_ONLY;
        // W without R is not a legal permission: the byte keeps its old value
        warl_reject        = wr_cfg.w && !wr_cfg.r;

        cfg_we   = IMPLEMENTED && cfg_sel && !entry_locked;
        cfg_new  = warl_reject ? cfg_cur : legal_cfg;
        addr_we  = IMPLEMENTED && addr_sel && !entry_locked && !next_tor_locked;
        addr_new = addr_wdata;
    end

endmodule

// File: rtl/pmp_cfg_regfile.sv
// PMP configuration register file: pmpcfg0..3 and pmpaddr0..15 behind a
// valid/ready CSR request channel with a one-cycle registered response.
// Writes commit on the accepting edge; reads (and writes) return the old
// value. Optional storage parity is enabled with the PMP_PARITY_EN macro,
// which also adds the parity_err_o port.
module pmp_cfg_regfile
    import pmp_cfg_pkg::*;
#(
    parameter int                     XLEN             = 32,
    parameter int                     PLEN             = 34,
    parameter int                     NrPMPEntries     = 8,
    parameter logic [15:0][7:0]       PMPCfgRstVal     = '0,
    parameter logic [15:0][PLEN-3:0]  PMPAddrRstVal    = '0,
    parameter logic [15:0]            PMPEntryReadOnly = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [11:0]               req_addr_i,
    input  logic [XLEN-1:0]           req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [XLEN-1:0]           rsp_rdata_o,
    output logic                      rsp_illegal_o,
    output logic [15:0][7:0]          pmpcfg_o,
    output logic [15:0][PLEN-3:0]     pmpaddr_o
`ifdef PMP_PARITY_EN
    ,
    output logic                      parity_err_o
`endif
);

    csr_state_e state_reg, state_next;
    logic       accept;

    logic       is_cfg;
    logic       is_addr;
    logic [1:0] cfg_idx;
    logic [3:0] addr_idx;
    logic [31:0]     cfg_word;
    logic [XLEN-1:0] rdata_next;
    logic            illegal_next;
    logic [PLEN-3:0] addr_wdata;

    logic [7:0]      cfg_reg  [MAX_PMP_ENTRIES];
    logic [PLEN-3:0] addr_reg [MAX_PMP_ENTRIES];
    logic [7:0]      cfg_new  [MAX_PMP_ENTRIES];
    logic [PLEN-3:0] addr_new [MAX_PMP_ENTRIES];
    logic [MAX_PMP_ENTRIES-1:0] cfg_sel;
    logic [MAX_PMP_ENTRIES-1:0] addr_sel;
    logic [MAX_PMP_ENTRIES-1:0] cfg_we;
    logic [MAX_PMP_ENTRIES-1:0] addr_we;

`ifdef PMP_PARITY_EN
    logic [MAX_PMP_ENTRIES-1:0] par_mismatch;
    logic                       parity_err_reg;
`endif

    // Handshake state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs: ready only while idle, valid only while responding
    always_comb begin
        state_next  = state_reg;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept     = req_valid_i && (state_reg == ST_IDLE);
    assign addr_wdata = (PLEN-2)'(req_wdata_i);

    // Address decode and read-data mux; unimplemented entries hold zero so read zero
    always_comb begin
        is_cfg       = (req_addr_i[11:2] == CSR_PMPCFG0[11:2]);
        is_addr      = (req_addr_i[11:4] == CSR_PMPADDR0[11:4]);
        cfg_idx      = req_addr_i[1:0];
        addr_idx     = req_addr_i[3:0];
        cfg_word     = '0;
        rdata_next   = '0;
        illegal_next = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cfg_word[8*j +: 8] = cfg_reg[{cfg_idx, 2'(j)}];
        end
        if (is_cfg) begin
            rdata_next = XLEN'(cfg_word);
        end else if (is_addr) begin
            rdata_next = XLEN'(addr_reg[addr_idx]);
        end else begin
            illegal_next = 1'b1;
        end
    end

    // Response capture at the accepting edge; held unchanged until the next acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_o   <= '0;
            rsp_illegal_o <= 1'b0;
        end else if (accept) begin
            rsp_rdata_o   <= rdata_next;
            rsp_illegal_o <= illegal_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_PMP_ENTRIES; gi++) begin : g_entry
            localparam bit              IMPL     = (gi < NrPMPEntries);
            localparam logic [7:0]      CFG_RST  = IMPL ? (PMPCfgRstVal[gi] & PMPCFG_WARL_MASK) : 8'h00;
            localparam logic [PLEN-3:0] ADDR_RST = IMPL ? PMPAddrRstVal[gi] : '0;

            logic next_tor_locked;

            if (gi < MAX_PMP_ENTRIES - 1) begin : g_above
                assign next_tor_locked = cfg_is_tor_locked(pmpcfg_t'(cfg_reg[gi+1]));
            end else begin : g_top
                assign next_tor_locked = 1'b0;
            end

            assign cfg_sel[gi]  = accept && req_we_i && is_cfg  && (cfg_idx  == 2'(gi / 4));
            assign addr_sel[gi] = accept && req_we_i && is_addr && (addr_idx == 4'(gi));

            pmp_entry_wr #(
                .PLEN        (PLEN),
                .READ_ONLY   (PMPEntryReadOnly[gi]),
                .IMPLEMENTED (IMPL)
            ) u_entry_wr (
                .cfg_sel         (cfg_sel[gi]),
                .addr_sel        (addr_sel[gi]),
                .cfg_wdata       (req_wdata_i[8*(gi%4) +: 8]),
                .addr_wdata      (addr_wdata),
                .cfg_cur         (cfg_reg[gi]),
                .next_tor_locked (next_tor_locked),
                .cfg_we          (cfg_we[gi]),
                .cfg_new         (cfg_new[gi]),
                .addr_we         (addr_we[gi]),
                .addr_new        (addr_new[gi])
            );

            // Entry storage; unimplemented entries reset to zero and are never written
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cfg_reg[gi]  <= CFG_RST;
                    addr_reg[gi] <= ADDR_RST;
                end else begin
                    if (cfg_we[gi]) begin
                        cfg_reg[gi] <= cfg_new[gi];
                    end
                    if (addr_we[gi]) begin
                        addr_reg[gi] <= addr_new[gi];
                    end
                end
            end

`ifdef PMP_PARITY_EN
            logic cfg_par_reg;
            logic addr_par_reg;

            // Even-parity bits written alongside the data they protect
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cfg_par_reg  <= ^CFG_RST;
                    addr_par_reg <= ^ADDR_RST;
                end else begin
                    if (cfg_we[gi]) begin
                        cfg_par_reg <= ^cfg_new[gi];
                    end
                    if (addr_we[gi]) begin
                        addr_par_reg <= ^addr_new[gi];
                    end
                end
            end

            assign par_mismatch[gi] = (^{cfg_reg[gi], cfg_par_reg}) | (^{addr_reg[gi], addr_par_reg});
`endif

            assign pmpcfg_o[gi]  = cfg_reg[gi];
            assign pmpaddr_o[gi] = addr_reg[gi];
        end
    endgenerate

`ifdef PMP_PARITY_EN
    // Sticky parity error: any mismatch on any entry latches until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_reg <= 1'b0;
        end else if (|par_mismatch) begin
            parity_err_reg <= 1'b1;
        end
    end

    assign parity_err_o = parity_err_reg;
`endif

endmodule

// File: tb/tb_pmp_cfg_regfile.sv
// Self-checking bench for pmp_cfg_regfile: a vector table of CSR accesses
// with expected responses fed through a scoreboard queue, followed by
// hand-written sequences for back-pressure, commit timing and mid-response reset.
module tb_pmp_cfg_regfile;

    localparam int XLEN = 32;
    localparam int PLEN = 34;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [11:0]           req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_rdata;
    logic                  rsp_illegal;
    logic [15:0][7:0]      pmpcfg;
    logic [15:0][PLEN-3:0] pmpaddr;
`ifdef PMP_PARITY_EN
    logic                  parity_err;
`endif

    always #5 clk = ~clk;

    pmp_cfg_regfile #(
        .XLEN             (XLEN),
        .PLEN             (PLEN),
        .NrPMPEntries     (8),
        .PMPCfgRstVal     ({{15{8'h00}}, 8'h8F}),
        .PMPAddrRstVal    ({{8{32'h0}}, 32'hDEAD_BEEF, {7{32'h0}}}),
        .PMPEntryReadOnly (16'h0040)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_illegal_o (rsp_illegal),
        .pmpcfg_o      (pmpcfg),
        .pmpaddr_o     (pmpaddr)
`ifdef PMP_PARITY_EN
        ,
        .parity_err_o  (parity_err)
`endif
    );

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete CSR transaction; hold = cycles of rsp_ready low after the response appears
    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_ill, input int hold);
        int   budget;
        exp_t e;
        @(negedge clk);
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        sb_q.push_back('{exp_rdata, exp_ill});
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("rsp_latency", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < hold; c++) begin
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, sb_q[0].rdata);
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("rdata@%h", addr), rsp_rdata, e.rdata);
            check($sformatf("illegal@%h", addr), 32'(rsp_illegal), 32'(e.ill));
        end
        $display("[TB] txn %0d we=%0b addr=%h wdata=%h rdata=%h illegal=%0b", n_txn, we, addr, wdata, rsp_rdata, rsp_illegal);
        n_txn++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // we, addr, wdata, expected rdata (old value on writes), expected illegal
        vecs.push_back('{1'b0, 12'h3A0, 32'h0000_0000, 32'h0000_008F, 1'b0});
        vecs.push_back('{1'b0, 12'h3B7, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 12'h3B0, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3A0, 32'h0000_0F9F, 32'h0000_008F, 1'b0});
        vecs.push_back('{1'b0, 12'h3A0, 32'h0000_0000, 32'h0000_0F8F, 1'b0});
        vecs.push_back('{1'b1, 12'h3A0, 32'h0000_8800, 32'h0000_0F8F, 1'b0});
        vecs.push_back('{1'b0, 12'h3A0, 32'h0000_0000, 32'h0000_888F, 1'b0});
        vecs.push_back('{1'b1, 12'h3B0, 32'h0000_1234, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B0, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3A0, 32'h8800_0000, 32'h0000_888F, 1'b0});
        vecs.push_back('{1'b0, 12'h3A0, 32'h0000_0000, 32'h8800_888F, 1'b0});
        vecs.push_back('{1'b1, 12'h3B2, 32'h0000_CAFE, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B2, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3B3, 32'h0000_5555, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B3, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3B1, 32'h0000_0042, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B1, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3A1, 32'h0B03_9003, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3A1, 32'h0000_0000, 32'h0B00_9003, 1'b0});
        vecs.push_back('{1'b1, 12'h3B4, 32'h00AB_CDEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B4, 32'h0000_0000, 32'h00AB_CDEF, 1'b0});
        vecs.push_back('{1'b1, 12'h3B5, 32'h0000_1111, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B5, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3B6, 32'h0000_2222, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B6, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3A1, 32'h0200_9001, 32'h0B00_9003, 1'b0});
        vecs.push_back('{1'b0, 12'h3A1, 32'h0000_0000, 32'h0B00_9001, 1'b0});
        vecs.push_back('{1'b1, 12'h3A1, 32'h6000_9001, 32'h0B00_9001, 1'b0});
        vecs.push_back('{1'b0, 12'h3A1, 32'h0000_0000, 32'h0000_9001, 1'b0});
        vecs.push_back('{1'b1, 12'h3A1, 32'h7F00_907F, 32'h0000_9001, 1'b0});
        vecs.push_back('{1'b0, 12'h3A1, 32'h0000_0000, 32'h1F00_901F, 1'b0});
        vecs.push_back('{1'b1, 12'h3B7, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 12'h3B7, 32'h0000_0000, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 12'h3A2, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3A2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3A2, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3A3, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h3B8, 32'h0000_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3B8, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3BF, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h3C0, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 12'h3C0, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 12'h3A4, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 12'h39F, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 12'h3AF, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 12'h3A0, 32'h0000_0000, 32'h8800_888F, 1'b0});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        check("rst_cfg0", 32'(pmpcfg[0]), 32'h8F);
        check("rst_cfg1", 32'(pmpcfg[1]), 32'h00);
        check("rst_addr7", 32'(pmpaddr[7]), 32'hDEAD_BEEF);
        rst_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_ill, 0);
        end

        // Live outputs after the table
        check("live_cfg1", 32'(pmpcfg[1]), 32'h88);
        check("live_cfg3", 32'(pmpcfg[3]), 32'h88);
        check("live_cfg5", 32'(pmpcfg[5]), 32'h90);
        check("live_cfg7", 32'(pmpcfg[7]), 32'h1F);
        check("live_cfg8", 32'(pmpcfg[8]), 32'h00);
        check("live_addr0", 32'(pmpaddr[0]), 32'h0);
        check("live_addr4", 32'(pmpaddr[4]), 32'h00AB_CDEF);

        // Back-pressure: response held for 5 cycles
        do_req(1'b0, 12'h3B4, 32'h0, 32'h00AB_CDEF, 1'b0, 5);

        // Commit timing: live output changes only after the accepting edge
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h3B4;
        req_wdata = 32'h1357_9BDF;
        check("commit_before_edge", 32'(pmpaddr[4]), 32'h00AB_CDEF);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("commit_after_edge", 32'(pmpaddr[4]), 32'h1357_9BDF);
        check("commit_old_rdata", rsp_rdata, 32'h00AB_CDEF);
        $display("[TB] txn %0d we=1 addr=3b4 wdata=13579bdf rdata=%h (commit timing)", n_txn, rsp_rdata);
        n_txn++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("commit_rsp_done", 32'(rsp_valid), 32'd0);

        // Reset asserted mid-response
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h3B4;
        req_wdata = 32'h7777_7777;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("midrst_rsp_valid_before", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_addr4", 32'(pmpaddr[4]), 32'h0);
        check("midrst_addr7", 32'(pmpaddr[7]), 32'hDEAD_BEEF);
        check("midrst_cfg0", 32'(pmpcfg[0]), 32'h8F);
        check("midrst_cfg7", 32'(pmpcfg[7]), 32'h00);
        $display("[TB] txn %0d we=1 addr=3b4 wdata=77777777 (reset mid-response)", n_txn);
        n_txn++;
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 12'h3B4, 32'h0, 32'h0000_0000, 1'b0, 0);
        do_req(1'b0, 12'h3A0, 32'h0, 32'h0000_008F, 1'b0, 0);
        do_req(1'b0, 12'h3C0, 32'h0, 32'h0000_0000, 1'b1, 2);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmp_cfg_regfile.md
PMP_CFG_REGFILE -- requirements
Module: pmp_cfg_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, CSR data width; only 32 is supported.
REQ-002 SHALL have parameter PLEN, default 34, physical address width.
REQ-003 SHALL have parameter NrPMPEntries, default 8, number of implemented entries (0..16).
REQ-004 SHALL have parameter PMPCfgRstVal, default all-zero, per-entry 8-bit cfg reset values.
REQ-005 SHALL have parameter PMPAddrRstVal, default all-zero, per-entry address reset values.
REQ-006 SHALL have parameter PMPEntryReadOnly, default 0, 16-bit mask; a set bit makes that entry immutable.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port req_valid_i / req_ready_o, input / output, 1 bit each: CSR request handshake.
REQ-010 SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr_i, input, 12 bits: CSR address.
REQ-012 SHALL have port req_wdata_i, input, XLEN bits: write data.
REQ-013 SHALL have port rsp_valid_o / rsp_ready_i, output / input, 1 bit each: response handshake.
REQ-014 SHALL have port rsp_rdata_o, output, XLEN bits: read data, equal to the old value on a write.
REQ-015 SHALL have port rsp_illegal_o, output, 1 bit: the address is not a PMP CSR.
REQ-016 SHALL have port pmpcfg_o, output, 16x8 bits: live cfg per entry.
REQ-017 SHALL have port pmpaddr_o, output, 16x(PLEN-2) bits: live address per entry.
REQ-018 SHALL have port parity_err_o, output, 1 bit: sticky storage parity error; exists only under PMP_PARITY_EN.

Function
REQ-019 SHALL implement FSM IDLE/RESP; req_ready_o=1 only in IDLE.
- IDLE --(req_valid_i)--> RESP: the request is captured and any write is committed at that edge.
- RESP --(rsp_ready_i)--> IDLE.
REQ-020 SHALL assert rsp_valid_o only in RESP, with a latency of exactly 1 cycle from acceptance; outputs SHALL stay stable while rsp_ready_i=0.
REQ-021 SHALL map pmpcfg0..3 to 0x3A0..0x3A3, each holding entries 4k..4k+3 with byte j = entry 4k+j.
REQ-022 SHALL map pmpaddr0..15 to 0x3B0..0x3BF, storing wdata[PLEN-3:0]; upper read bits SHALL be zero.
REQ-023 SHALL ignore writes to entries with index >= NrPMPEntries, which SHALL read zero and SHALL not be flagged illegal.
REQ-024 SHALL ignore a cfg byte write when the stored L bit (bit 7) is set or PMPEntryReadOnly[i]=1; other bytes of the same word SHALL still update.
REQ-025 SHALL ignore a pmpaddr[i] write when entry i is locked/read-only, or when entry i+1 is locked with A=TOR (bits 4:3 = 01).
REQ-026 SHALL apply WARL to a cfg byte with R=0,W=1: the whole byte SHALL keep its old value; bits 6:5 SHALL always read zero.
REQ-027 SHALL flag any other address as illegal: rsp_illegal_o=1, rdata=0, no state change.
REQ-028 SHALL update pmpcfg_o/pmpaddr_o on the cycle after the committing edge.
REQ-029 SHALL apply the lock rule per byte using pre-write state when a single cfg write sets L and changes A in the same byte.

Reset
REQ-030 SHALL on rst_ni=0 asynchronously force: state IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_illegal_o=0, cfg/addr = PMPCfgRstVal/PMPAddrRstVal (implemented entries, others zero), parity_err_o=0.
REQ-031 SHALL discard a pending response when reset is asserted mid-response; no partial write SHALL survive.

Configuration
REQ-032 SHALL, with PMP_PARITY_EN defined, store one even-parity bit per cfg byte and per address entry, check every cycle, and set parity_err_o sticky until reset.
REQ-033 SHALL, without PMP_PARITY_EN, omit the parity storage and the parity_err_o port.

Structure
REQ-034 SHALL place the CSR address constants, the pmpcfg bit-field typedef and the A-field encoding enum (OFF/TOR/NA4/NAPOT) in a shared package pmp_cfg_pkg.
REQ-035 SHALL instantiate one sub-module, pmp_entry_wr, holding the per-entry write-enable/lock/WARL logic, once per entry.

Verification
REQ-036 SHALL cover: after reset with PMPCfgRstVal[0]=8'h8F, read 0x3A0 -> rdata[7:0]=8'h8F, rsp_valid_o one cycle after acceptance.
REQ-037 SHALL cover: write 0x3A0=32'h0000_0F9F with entry 0 locked -> byte0 unchanged, byte1=8'h0F.
REQ-038 SHALL cover: entry 1 cfg=8'h88 (L, TOR), write 0x3B0=32'h1234 -> pmpaddr_o[0] unchanged.
REQ-039 SHALL cover: write cfg byte 8'h02 (W without R) -> byte keeps its old value; write 8'h60 -> reads 8'h00.
REQ-040 SHALL cover: NrPMPEntries=8, read 0x3A2 -> 0, not illegal; read 0x3C0 -> rsp_illegal_o=1.
REQ-041 SHALL cover: hold rsp_ready_i=0 for 5 cycles -> req_ready_o=0 and response stable; assert rst_ni=0 mid-response -> rsp_valid_o=0 immediately.
